// File: rtl/fp16_pkg.sv
// Shared types and FP16 constants for the dot-product sequencer.
package fp16_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    MUL,
    ADD,
    ACC,
    DONE
  } state_t;

  localparam logic [15:0] FP16_ZERO     = 16'h0000;
  localparam logic [15:0] FP16_ONE      = 16'h3C00;
  localparam int          FP16_SIGN_BIT = 15;
  localparam logic        OP_MUL        = 1'b1;
  localparam logic        OP_ADD        = 1'b0;

endpackage

// File: rtl/fp16_dot_sequencer_if.sv
// Operand stream, FPU drive and result handshake of the dot-product sequencer.
// slave: the sequencer side; master: the surrounding system (source, FPU, sink).
interface fp16_dot_sequencer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  len;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  fpu_en;
  logic                  fpu_dec;
  logic [DATA_WIDTH-1:0] fpu_a;
  logic [DATA_WIDTH-1:0] fpu_b;
  logic [DATA_WIDTH-1:0] fpu_result;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  busy;

  modport slave (
    input  start, len, in_valid, in_a, in_b, fpu_result, out_ready,
    output in_ready, fpu_en, fpu_dec, fpu_a, fpu_b, out_valid, out_data, busy
  );

  modport master (
    output start, len, in_valid, in_a, in_b, fpu_result, out_ready,
    input  in_ready, fpu_en, fpu_dec, fpu_a, fpu_b, out_valid, out_data, busy
  );
endinterface

// File: rtl/fp16_relu.sv
// Combinational ReLU on an FP16 word: any negative value (including -0) becomes +0.
module fp16_relu
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  assign dout = din[FP16_SIGN_BIT] ? FP16_ZERO : din;

endmodule

// File: rtl/fp16_dot_sequencer.sv
// FP16 dot-product sequencer: feeds an external 1-cycle FPU a multiply then an
// accumulate-add per operand pair and returns one dot product per job.
// Optional feature: define DOT_RELU_EN to clamp negative results to +0 at the output.
module fp16_dot_sequencer
  import fp16_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  fp16_dot_sequencer_if.slave    bus
);

  state_t                state;
  logic [DATA_WIDTH-1:0] acc;
  logic [LEN_WIDTH-1:0]  count;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [DATA_WIDTH-1:0] a_q;
  logic [DATA_WIDTH-1:0] b_q;
  logic                  in_ready_q;
  logic                  fpu_en_q;
  logic                  fpu_dec_q;
  logic                  out_valid_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] acc_out;
  logic                  first_pair;

  // The first product seeds acc directly; the FPU mishandles a zero addend.
  assign first_pair = (count == '0);

  // Sequencer FSM; control outputs are registered alongside the state they belong to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      acc         <= '0;
      count       <= '0;
      len_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      in_ready_q  <= 1'b0;
      fpu_en_q    <= 1'b0;
      fpu_dec_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            acc    <= FP16_ZERO;
            count  <= '0;
            len_q  <= bus.len;
            busy_q <= 1'b1;
            if (bus.len != '0) begin
              state      <= FETCH;
              in_ready_q <= 1'b1;
            end else begin
              state       <= DONE;
              out_valid_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (bus.in_valid) begin
            a_q        <= bus.in_a;
            b_q        <= bus.in_b;
            in_ready_q <= 1'b0;
            fpu_en_q   <= 1'b1;
            fpu_dec_q  <= OP_MUL;
            state      <= MUL;
          end
        end
        MUL: begin
          fpu_en_q  <= !first_pair;
          fpu_dec_q <= OP_ADD;
          state     <= ADD;
        end
        ADD: begin
          if (first_pair) acc <= bus.fpu_result;
          fpu_en_q <= 1'b0;
          state    <= ACC;
        end
        ACC: begin
          if (!first_pair) acc <= bus.fpu_result;
          count <= count + LEN_WIDTH'(1);
          if (count + LEN_WIDTH'(1) == len_q) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            state      <= FETCH;
            in_ready_q <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand muxes: the product must pass straight through to the add in the
  // same cycle it appears, so these follow the state rather than a register.
  assign bus.fpu_a = (state == MUL)                ? a_q :
                     (state == ADD && !first_pair) ? acc : '0;
  assign bus.fpu_b = (state == MUL)                ? b_q :
                     (state == ADD && !first_pair) ? bus.fpu_result : '0;

`ifdef DOT_RELU_EN
  fp16_relu #(.DATA_WIDTH(DATA_WIDTH)) u_relu (
    .din  (acc),
    .dout (acc_out)
  );
`else
  assign acc_out = acc;
`endif

  assign bus.in_ready  = in_ready_q;
  assign bus.fpu_en    = fpu_en_q;
  assign bus.fpu_dec   = fpu_dec_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_valid_q ? acc_out : '0;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp16_dot_sequencer.sv
// Bench for fp16_dot_sequencer: behavioural FP16 FPU alongside the DUT, directed
// jobs from the behaviour list plus random small-integer dot products.
module tb_fp16_dot_sequencer;
  import fp16_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   hs    = 0;
  int   irdy  = 0;

  fp16_dot_sequencer_if bus ();

  fp16_dot_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // FP16 <-> real; bench values are small integers, so conversions are exact.
  function automatic real h2r(input logic [15:0] h);
    real m;
    int  e;
    e = int'(h[14:10]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(h[9:0]) / 1024.0;
    while (e > 15) begin m = m * 2.0; e--; end
    while (e < 15) begin m = m / 2.0; e++; end
    return h[15] ? -m : m;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real  m;
    int   e;
    int   f;
    logic s;
    if (r == 0.0) return 16'h0000;
    s = (r < 0.0);
    m = s ? -r : r;
    e = 15;
    while (m >= 2.0) begin m = m / 2.0; e++; end
    while (m < 1.0)  begin m = m * 2.0; e--; end
    f = $rtoi((m - 1.0) * 1024.0);
    return {s, 5'(e), 10'(f)};
  endfunction

  function automatic logic [15:0] expect_out(input logic [15:0] h);
`ifdef DOT_RELU_EN
    return h[15] ? 16'h0000 : h;
`else
    return h;
`endif
  endfunction

  // External FPU model: registered result one cycle after en.
  always @(posedge clk or posedge reset) begin
    if (reset) bus.fpu_result <= 16'h0000;
    else if (bus.fpu_en)
      bus.fpu_result <= bus.fpu_dec ? r2h(h2r(bus.fpu_a) * h2r(bus.fpu_b))
                                    : r2h(h2r(bus.fpu_a) + h2r(bus.fpu_b));
  end

  // Cycle counter and handshake / in_ready monitors.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) hs <= hs + 1;
    if (bus.in_ready) irdy <= irdy + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [15:0] va [0:15];
  logic [15:0] vb [0:15];

  task automatic feed_pair(input logic [15:0] a, input logic [15:0] b, input int gap);
    int k;
    repeat (gap) begin @(posedge clk); #1; end
    bus.in_valid = 1'b1;
    bus.in_a = a;
    bus.in_b = b;
    k = 0;
    while (!bus.in_ready && k < 200) begin @(posedge clk); #1; k++; end
    if (k >= 200) chk("fetch_timeout", 1, 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_a = 16'h0000;
    bus.in_b = 16'h0000;
  endtask

  task automatic do_job(input string tag, input int n, input int gap, input int hold,
                        input bit dup_start, input logic [15:0] exp_h, input int exp_lat);
    int k;
    int t0;
    int hs0;
    int ir0;
    logic [15:0] held;
    hs0 = hs;
    ir0 = irdy;
    bus.start = 1'b1;
    bus.len = 8'(n);
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.len = 8'($urandom_range(1, 200));
    for (int i = 0; i < n; i++) begin
      feed_pair(va[i], vb[i], gap);
      if (dup_start && i == 0) begin
        bus.start = 1'b1;
        bus.len = 8'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
      end
    end
    k = 0;
    while (!bus.out_valid && k < 500) begin @(posedge clk); #1; k++; end
    chk({tag, "_done_timeout"}, (k >= 500) ? 1 : 0, 0);
    if (exp_lat >= 0) chk({tag, "_latency"}, cyc - t0, exp_lat);
    chk({tag, "_data"}, bus.out_data, exp_h);
    held = bus.out_data;
    if (hold > 0) begin
      repeat (hold) begin @(posedge clk); #1; end
      chk({tag, "_hold_valid"}, bus.out_valid, 1);
      chk({tag, "_hold_data"}, bus.out_data, held);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({tag, "_after_valid"}, bus.out_valid, 0);
    chk({tag, "_after_busy"}, bus.busy, 0);
    chk({tag, "_handshakes"}, hs - hs0, n);
    if (n == 0) chk({tag, "_no_in_ready"}, irdy - ir0, 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_fpu_en"}, bus.fpu_en, 0);
    chk({tag, "_fpu_dec"}, bus.fpu_dec, 0);
    chk({tag, "_fpu_a"}, bus.fpu_a, 0);
    chk({tag, "_fpu_b"}, bus.fpu_b, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  initial begin
    int   n;
    int   gap;
    int   hold;
    int   k;
    real  sum;
    int   ia;
    int   ib;

    reset = 1'b1;
    bus.start = 1'b0;
    bus.len = 8'd0;
    bus.in_valid = 1'b0;
    bus.in_a = 16'h0000;
    bus.in_b = 16'h0000;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // [1,2].[2,3] = 8.0, 9-cycle latency
    va[0] = FP16_ONE; vb[0] = 16'h4000;
    va[1] = 16'h4000; vb[1] = 16'h4200;
    do_job("dot2", 2, 0, 0, 1'b0, expect_out(16'h4800), 9);

    // single negative product, then back-to-back start
    va[0] = 16'hBC00; vb[0] = FP16_ONE;
    do_job("neg1", 1, 0, 0, 1'b0, expect_out(16'hBC00), 5);

    // zero-length job
    do_job("len0", 0, 0, 0, 1'b0, FP16_ZERO, 1);

    // input gaps and output back-pressure
    va[0] = FP16_ONE; vb[0] = 16'h4000;
    va[1] = 16'h4000; vb[1] = 16'h4200;
    do_job("stall", 2, 3, 5, 1'b0, expect_out(16'h4800), -1);

    // cancellation to zero with an ignored start while busy
    va[0] = FP16_ONE; vb[0] = 16'h4000;
    va[1] = 16'hBC00; vb[1] = 16'h4000;
    do_job("cancel", 2, 0, 0, 1'b1, FP16_ZERO, -1);

    // reset while in ADD of the second pair
    bus.start = 1'b1;
    bus.len = 8'd2;
    @(posedge clk); #1;
    bus.start = 1'b0;
    feed_pair(FP16_ONE, 16'h4000, 0);
    feed_pair(16'h4000, 16'h4200, 0);
    @(posedge clk); #1;
    chk("pre_reset_fpu_en", bus.fpu_en, 1);
    reset = 1'b1;
    #1;
    chk_all_zero("midjob_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    k = hs;
    repeat (5) begin @(posedge clk); #1; end
    chk("post_reset_idle_valid", bus.out_valid, 0);
    chk("post_reset_no_hs", hs - k, 0);
    va[0] = 16'h4200; vb[0] = 16'h4200;
    va[1] = FP16_ONE; vb[1] = 16'hC000;
    do_job("after_reset", 2, 0, 0, 1'b0, expect_out(r2h(9.0 - 2.0)), 9);

    // random small-integer dot products against a real-valued sum
    for (int j = 0; j < 12; j++) begin
      n    = $urandom_range(1, 6);
      gap  = $urandom_range(0, 2);
      hold = $urandom_range(0, 3);
      sum  = 0.0;
      for (int i = 0; i < n; i++) begin
        ia = $urandom_range(0, 8) - 4;
        ib = $urandom_range(0, 8) - 4;
        va[i] = r2h(real'(ia));
        vb[i] = r2h(real'(ib));
        sum = sum + real'(ia * ib);
      end
      do_job($sformatf("rnd%0d", j), n, gap, hold, 1'b0, expect_out(r2h(sum)),
             (gap == 0) ? 4 * n + 1 : -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
